// File: rtl/fc2_10inputs_serializer.sv
// fc2_10inputs_serializer: captures a 10-word FC2 frame in one handshake and
// streams it out word by word (data_in_1 first) on a valid/ready channel.
module fc2_10inputs_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WORDS  = 10,
    parameter int INDEX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [DATA_WIDTH-1:0] data_in_1,
    input  logic [DATA_WIDTH-1:0] data_in_2,
    input  logic [DATA_WIDTH-1:0] data_in_3,
    input  logic [DATA_WIDTH-1:0] data_in_4,
    input  logic [DATA_WIDTH-1:0] data_in_5,
    input  logic [DATA_WIDTH-1:0] data_in_6,
    input  logic [DATA_WIDTH-1:0] data_in_7,
    input  logic [DATA_WIDTH-1:0] data_in_8,
    input  logic [DATA_WIDTH-1:0] data_in_9,
    input  logic [DATA_WIDTH-1:0] data_in_10,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [INDEX_BITS-1:0] out_index,
    output logic                  out_last,
    output logic                  busy
);
    typedef enum logic {IDLE, SEND} state_t;
    localparam logic [INDEX_BITS-1:0] LAST = INDEX_BITS'(NUM_WORDS - 1);

    state_t                state;
    logic [INDEX_BITS-1:0] index;
    logic [DATA_WIDTH-1:0] buffer [NUM_WORDS];
    logic [DATA_WIDTH-1:0] frame  [NUM_WORDS];
    logic                  at_last;

    assign frame[0] = data_in_1;
    assign frame[1] = data_in_2;
    assign frame[2] = data_in_3;
    assign frame[3] = data_in_4;
    assign frame[4] = data_in_5;
    assign frame[5] = data_in_6;
    assign frame[6] = data_in_7;
    assign frame[7] = data_in_8;
    assign frame[8] = data_in_9;
    assign frame[9] = data_in_10;

    assign at_last    = index == LAST;
    assign out_valid  = state == SEND;
    assign busy       = out_valid;
    assign out_index  = index;
    assign out_last   = out_valid & at_last;
    assign data_out   = out_valid ? buffer[index] : '0;
    // A new frame may land on the same edge the final word is taken.
    assign load_ready = !out_valid | (at_last & out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            index <= '0;
            for (int k = 0; k < NUM_WORDS; k++) buffer[k] <= '0;
        end else if (load_valid && load_ready) begin
            buffer <= frame;
            index  <= '0;
            state  <= SEND;
        end else if (out_valid && out_ready) begin
            state <= at_last ? IDLE : SEND;
            index <= at_last ? '0 : index + 1'b1;
        end
    end
endmodule

// File: tb/tb_fc2_10inputs_serializer.sv
// tb_fc2_10inputs_serializer: randomized stimulus with a queue scoreboard and a
// behavioural shift-FIFO model for the round-trip check.
module tb_fc2_10inputs_serializer;
    typedef struct {
        logic [31:0] data;
        int          idx;
        logic        last;
    } beat_t;

    logic        clk = 0;
    logic        reset;
    logic        load_valid;
    logic        load_ready;
    logic [31:0] din [10];
    logic        out_valid;
    logic        out_ready;
    logic [31:0] data_out;
    logic [3:0]  out_index;
    logic        out_last;
    logic        busy;

    beat_t       q[$];
    logic [31:0] fifo [10];
    logic [31:0] saved [10];
    int          checks = 0;
    int          errors = 0;
    int          beats = 0;
    int          b0;

    fc2_10inputs_serializer dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .data_in_1(din[0]), .data_in_2(din[1]), .data_in_3(din[2]), .data_in_4(din[3]),
        .data_in_5(din[4]), .data_in_6(din[5]), .data_in_7(din[6]), .data_in_8(din[7]),
        .data_in_9(din[8]), .data_in_10(din[9]),
        .out_valid(out_valid), .out_ready(out_ready), .data_out(data_out),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is a queue of 10 pending beats; the block is idle when it is empty.
    always @(negedge clk) begin
        logic exp_lr;
        if (reset) q.delete();
        else begin
            exp_lr = q.size() == 0 || (q.size() == 1 && out_ready);
            chk("load_ready", load_ready, exp_lr);
            chk("out_valid", out_valid, q.size() != 0);
            chk("busy", busy, q.size() != 0);
            if (q.size() != 0) begin
                chk("data_out", data_out, q[0].data);
                chk("out_index", out_index, q[0].idx);
                chk("out_last", out_last, q[0].last);
                if (out_ready) begin
                    for (int k = 0; k < 9; k++) fifo[k] = fifo[k+1];
                    fifo[9] = data_out;
                    void'(q.pop_front());
                    beats++;
                end
            end
            if (load_valid && exp_lr)
                for (int k = 0; k < 10; k++) q.push_back('{din[k], k, k == 9});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_din();
        for (int k = 0; k < 10; k++) din[k] = $urandom;
    endtask

    task automatic load();
        saved = din;
        load_valid = 1;
        step();
        load_valid = 0;
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0,1, 2: random ready
    task automatic drain(input int mode);
        for (int c = 0; c < 200 && q.size() != 0; c++) begin
            out_ready = mode == 0 ? 1'b1 : mode == 1 ? (c % 4 == 0 || c % 4 == 3) : 1'($urandom_range(0, 1));
            step();
        end
        chk("drain_pending", q.size(), 0);
        out_ready = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1;
        load_valid = 1;
        out_ready = 0;
        for (int k = 0; k < 10; k++) fifo[k] = '0;
        rand_din();
        repeat (3) begin
            rand_din();
            step();
        end
        reset = 0;
        load_valid = 0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_load_ready", load_ready, 1);
        chk("rst_out_index", out_index, 0);
        repeat (3) step();

        out_ready = 1;
        for (int k = 0; k < 10; k++) din[k] = 32'h0000_0100 + k + 1;
        b0 = beats;
        load();
        drain(0);
        chk("single_beats", beats - b0, 10);

        b0 = beats;
        load();
        drain(1);
        chk("bp_beats", beats - b0, 10);

        out_ready = 1;
        for (int k = 0; k < 10; k++) din[k] = 32'hA1 + k;
        b0 = beats;
        load();
        for (int k = 0; k < 10; k++) din[k] = 32'hB1 + k;
        repeat (9) step();
        load_valid = 1;
        step();
        load_valid = 0;
        repeat (10) step();
        chk("b2b_beats", beats - b0, 20);
        drain(0);

        rand_din();
        load();
        repeat (3) step();
        for (int k = 0; k < 10; k++) din[k] = 32'hDEAD_0000 + k;
        load_valid = 1;
        step();
        load_valid = 0;
        drain(0);

        rand_din();
        load();
        drain(2);
        for (int k = 0; k < 10; k++) chk($sformatf("fifo_%0d", k + 1), fifo[k], saved[k]);

        rand_din();
        load();
        repeat (5) step();
        reset = 1;
        step();
        reset = 0;
        @(negedge clk);
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_load_ready", load_ready, 1);
        rand_din();
        load();
        drain(0);

        repeat (300) begin
            rand_din();
            load_valid = $urandom_range(0, 3) == 0;
            out_ready = $urandom_range(0, 3) != 0;
            step();
        end
        load_valid = 0;
        drain(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
